inst_fetch_unit: RTL and testbench
==================================

# inst_fetch_unit

Multithreaded instruction fetch engine: the requesting side of the byte-wide instruction ROM port. Holds one PC per hardware thread, selects threads round-robin, and issues four consecutive byte reads per instruction. Assembles the bytes little-endian into a 32-bit word and presents it to decode over a valid/ready handshake. Accepts per-thread PC redirects from execute.

## Interface
- NUM_THREADS, 4, hardware thread count (power of 2, 2..8)
- TID_W, $clog2(NUM_THREADS), thread id width
- RESET_PC, 32'h0, PC value of every thread after reset

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- InstByteAddress  out  32  byte address to ROM
- InstRead  out  1  ROM read enable; data returns on InstIn in the next cycle
- InstIn  in  8  ROM byte, valid the cycle after an InstRead cycle
- thread_enable  in  NUM_THREADS  per-thread fetch enable
- redirect_valid  in  1  PC redirect strobe
- redirect_thread  in  TID_W  thread being redirected
- redirect_pc  in  32  new PC for that thread
- inst_valid  out  1  inst_word/inst_pc/inst_thread valid
- inst_ready  in  1  decode accepts the instruction
- inst_word  out  32  assembled instruction
- inst_pc  out  32  byte address of byte 0 of inst_word
- inst_thread  out  TID_W  thread owning inst_word

## Operation
- States: IDLE, FETCH, HOLD.
- IDLE: choose the next enabled thread, scanning from (last_thread+1) mod NUM_THREADS upward, wrapping. After reset, thread 0 is scanned first. None enabled -> stay in IDLE. Otherwise latch thread id and its PC, then go to FETCH.
- FETCH: 5-cycle byte counter c = 0..4.
  - c = 0..3: InstRead=1, InstByteAddress = pc + c, modulo 2^32 (wraps at 32'hFFFFFFFF).
  - c = 1..4: capture InstIn into byte c-1.
  - Byte 0 goes to inst_word[7:0] and byte 3 to [31:24].
  - After c = 4, go to HOLD with inst_valid=1.
- No alignment is enforced; a PC with low bits != 0 fetches pc..pc+3.
- HOLD: inst_valid=1 and outputs stable until inst_ready. On handshake:
  - the thread's PC += 4;
  - last_thread = inst_thread;
  - go to IDLE; selection happens in that IDLE cycle.
- Dropping thread_enable mid-fetch or in HOLD does not abort. The instruction completes and is delivered; that thread is not selected again until re-enabled.
- Redirect:
  - Always writes redirect_pc into the target thread's PC. It overrides the +4 update if both happen in the same cycle.
  - Target thread in FETCH: abort the fetch, InstRead=0 next cycle, go to IDLE. last_thread is unchanged, so the redirected thread is not re-selected first.
  - Target thread in HOLD: inst_valid drops next cycle, the instruction is discarded, go to IDLE. This applies even if inst_ready is high in the same cycle; decode must ignore the handshake when it redirects the same thread.
  - Redirect to any other thread only updates that thread's PC.
- InstByteAddress holds its last value when InstRead=0.

## Timing
- Reset (async assert, sync release) values:
  - state IDLE;
  - InstRead 0, InstByteAddress 0;
  - inst_valid 0, inst_word 0, inst_pc 0, inst_thread 0;
  - all PCs RESET_PC;
  - last_thread NUM_THREADS-1.
- Reset mid-fetch or mid-HOLD discards everything immediately.
- Cycle map: IDLE at cycle t; reads at t+1..t+4; captures at t+2..t+5; inst_valid high from t+6.
- Throughput: one instruction per 7 cycles with inst_ready tied high. The HOLD cycle with the handshake is followed by one IDLE cycle.
- InstRead is never high in IDLE or HOLD.

## Test plan
- Reset, RESET_PC=0, thread_enable=4'b0001, ROM bytes 0..3 = 13,05,A0,00:
  - InstRead high cycles 1..4 with addresses 0,1,2,3;
  - inst_valid at cycle 6 with inst_word=32'h00A00513, inst_pc=0, inst_thread=0.
- All four threads enabled, inst_ready=1:
  - inst_thread sequence is 0,1,2,3,0,1,…;
  - each thread's inst_pc advances 0,4,8 on its own turns.
- inst_ready low for 10 cycles in HOLD:
  - inst_valid and all outputs stable;
  - InstRead stays 0;
  - the PC increments only on the accepting cycle.
- Redirect thread 1 to 32'h100 while thread 1 is at FETCH c=2:
  - fetch aborted, no inst_valid for it;
  - the next thread 1 fetch reads 0x100..0x103.
- Redirect thread 2 in HOLD with inst_ready=1 in the same cycle:
  - instruction dropped, PC = redirect_pc (not +4);
  - a redirect to thread 3 in the same scenario changes only thread 3's PC.
- Redirect to 32'hFFFFFFFE: addresses FFFFFFFE, FFFFFFFF, 0, 1; with thread_enable=0, the block stays in IDLE and InstRead stays 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: multithreaded instruction fetch engine.
//
// Keeps one PC per hardware thread and picks threads round-robin. For each
// instruction it reads four consecutive bytes from a byte-wide ROM with one
// cycle of read latency. The bytes are assembled little-endian into a
// 32-bit word, which is offered to decode over a valid/ready handshake.
// Execute can redirect any thread's PC at any time.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   InstByteAddress     byte address to the ROM (held while InstRead is low)
//   InstRead            ROM read enable; data is returned on InstIn one cycle later
//   InstIn              ROM read data
//   thread_enable       per-thread fetch enable
//   redirect_valid      PC redirect strobe
//   redirect_thread     thread being redirected
//   redirect_pc         new PC for that thread
//   inst_valid          inst_word/inst_pc/inst_thread are valid
//   inst_ready          decode accepts the instruction
//   inst_word           assembled instruction
//   inst_pc             byte address of byte 0 of inst_word
//   inst_thread         thread that owns inst_word
module inst_fetch_unit #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned TID_W       = $clog2(NUM_THREADS),
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic [31:0]            InstByteAddress,
  output logic                   InstRead,
  input  logic [7:0]             InstIn,
  input  logic [NUM_THREADS-1:0] thread_enable,
  input  logic                   redirect_valid,
  input  logic [TID_W-1:0]       redirect_thread,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_word,
  output logic [31:0]            inst_pc,
  output logic [TID_W-1:0]       inst_thread
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e           state_q;
  logic [31:0]      pc_q [NUM_THREADS];
  logic [TID_W-1:0] last_q;
  logic [TID_W-1:0] cur_tid_q;
  logic [31:0]      cur_pc_q;
  logic [2:0]       cnt_q;
  logic [23:0]      bytes_q;

  // Round-robin pick: scan from last_q+1 upward, wrapping back to last_q.
  logic             sel_found;
  logic [TID_W-1:0] sel_tid;
  logic [TID_W-1:0] cand;
  logic [31:0]      sel_pc;
  logic             redirect_hit;

  always_comb begin
    sel_found = 1'b0;
    sel_tid   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      cand = last_q + TID_W'(i);
      if (!sel_found && thread_enable[cand]) begin
        sel_found = 1'b1;
        sel_tid   = cand;
      end
    end
  end

  // A redirect that lands in the same cycle as the thread's selection must be
  // seen by the new fetch. Otherwise the fetch would run from a stale PC, and
  // its +4 would then overwrite the redirect target.
  assign sel_pc = (redirect_valid && (redirect_thread == sel_tid)) ? redirect_pc
                                                                   : pc_q[sel_tid];

  assign redirect_hit = redirect_valid && (redirect_thread == cur_tid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      for (int i = 0; i < NUM_THREADS; i++) pc_q[i] <= RESET_PC;
      last_q          <= TID_W'(NUM_THREADS - 1);
      cur_tid_q       <= '0;
      cur_pc_q        <= '0;
      cnt_q           <= '0;
      bytes_q         <= '0;
      InstRead        <= 1'b0;
      InstByteAddress <= '0;
      inst_valid      <= 1'b0;
      inst_word       <= '0;
      inst_pc         <= '0;
      inst_thread     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sel_found) begin
            cur_tid_q       <= sel_tid;
            cur_pc_q        <= sel_pc;
            cnt_q           <= '0;
            InstRead        <= 1'b1;
            InstByteAddress <= sel_pc;
            state_q         <= StFetch;
          end
        end
        StFetch: begin
          if (redirect_hit) begin
            InstRead <= 1'b0;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 3'd1;
            // Reads occupy c=0..3; the address for c+1 is set up at the end of c.
            if (cnt_q < 3'd3) begin
              InstByteAddress <= cur_pc_q + 32'(cnt_q) + 32'd1;
            end else begin
              InstRead <= 1'b0;
            end
            // Byte c-1 arrives during c. After three shifts bytes_q = {b2,b1,b0}.
            if (cnt_q == 3'd4) begin
              inst_word   <= {InstIn, bytes_q};
              inst_pc     <= cur_pc_q;
              inst_thread <= cur_tid_q;
              inst_valid  <= 1'b1;
              state_q     <= StHold;
            end else if (cnt_q != 3'd0) begin
              bytes_q <= {InstIn, bytes_q[23:8]};
            end
          end
        end
        StHold: begin
          if (redirect_hit) begin
            // A same-thread redirect discards the instruction even if ready is high.
            inst_valid <= 1'b0;
            state_q    <= StIdle;
          end else if (inst_ready) begin
            inst_valid       <= 1'b0;
            pc_q[cur_tid_q]  <= cur_pc_q + 32'd4;
            last_q           <= cur_tid_q;
            state_q          <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Placed after the +4 update so that a redirect always wins.
      if (redirect_valid) pc_q[redirect_thread] <= redirect_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit. A transaction-level model tracks each
// thread's PC, the round-robin pointer and the cycles elapsed since the
// current fetch was chosen; expected port values are derived from that.
module tb_inst_fetch_unit;

  localparam int NT = 4;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   InstByteAddress;
  logic          InstRead;
  logic [7:0]    InstIn = 8'h00;
  logic [NT-1:0] thread_enable = '0;
  logic          redirect_valid = 1'b0;
  logic [TW-1:0] redirect_thread = '0;
  logic [31:0]   redirect_pc = '0;
  logic          inst_valid;
  logic          inst_ready = 1'b0;
  logic [31:0]   inst_word;
  logic [31:0]   inst_pc;
  logic [TW-1:0] inst_thread;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .NUM_THREADS(NT),
    .TID_W      (TW),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .InstByteAddress(InstByteAddress),
    .InstRead       (InstRead),
    .InstIn         (InstIn),
    .thread_enable  (thread_enable),
    .redirect_valid (redirect_valid),
    .redirect_thread(redirect_thread),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_word      (inst_word),
    .inst_pc        (inst_pc),
    .inst_thread    (inst_thread)
  );

  // ROM contents: bytes 0..3 = 13,05,A0,00; elsewhere an address hash.
  function automatic logic [7:0] rom_byte(input logic [31:0] a);
    logic [31:0] w;
    w = 32'h00A00513;
    if (a < 32'd4) return 8'(w >> (8 * a));
    return 8'((a * 32'd2654435761) >> 24) ^ a[7:0];
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {rom_byte(a + 32'd3), rom_byte(a + 32'd2), rom_byte(a + 32'd1), rom_byte(a)};
  endfunction

  // ROM with one cycle of read latency; returns garbage when not read.
  always @(posedge clk) InstIn <= InstRead ? rom_byte(InstByteAddress) : 8'($urandom);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [31:0] m_pc [NT];
  int          m_last;
  bit          m_busy;   // a fetch/hold is in progress
  int          m_k;      // cycles since the fetch was chosen
  int          m_tid;
  logic [31:0] m_fpc;
  logic [31:0] m_addr;   // last address presented to the ROM

  task automatic model_reset();
    for (int i = 0; i < NT; i++) m_pc[i] = 32'h0;
    m_last = NT - 1;
    m_busy = 0;
    m_k    = 0;
    m_tid  = 0;
    m_fpc  = 0;
    m_addr = 0;
  endtask

  // Reads run 1..4 cycles after selection; the word is valid from 6 cycles on.
  task automatic check_outputs();
    bit exp_rd;
    bit exp_v;
    exp_rd = m_busy && m_k >= 1 && m_k <= 4;
    exp_v  = m_busy && m_k >= 6;
    if (exp_rd) m_addr = m_fpc + 32'(m_k - 1);
    check_eq("InstRead", 32'(InstRead), 32'(exp_rd));
    check_eq("InstByteAddress", InstByteAddress, m_addr);
    check_eq("inst_valid", 32'(inst_valid), 32'(exp_v));
    if (exp_v) begin
      check_eq("inst_word", inst_word, rom_word(m_fpc));
      check_eq("inst_pc", inst_pc, m_fpc);
      check_eq("inst_thread", 32'(inst_thread), 32'(m_tid));
    end
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit found;
    int c;
    found = 0;
    if (!m_busy) begin
      for (int i = 1; i <= NT; i++) begin
        c = (m_last + i) % NT;
        if (!found && thread_enable[c]) begin
          found  = 1;
          m_busy = 1;
          m_k    = 1;
          m_tid  = c;
          m_fpc  = (redirect_valid && int'(redirect_thread) == c) ? redirect_pc : m_pc[c];
        end
      end
    end else if (redirect_valid && int'(redirect_thread) == m_tid) begin
      m_busy = 0;
    end else if (m_k < 6) begin
      m_k++;
    end else if (inst_ready) begin
      m_pc[m_tid] = m_fpc + 32'd4;
      m_last      = m_tid;
      m_busy      = 0;
    end
    if (redirect_valid) m_pc[redirect_thread] = redirect_pc;
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int n);
    repeat (n) run_cycle();
  endtask

  task automatic pulse_redirect(input int t, input logic [31:0] pc);
    redirect_valid  = 1'b1;
    redirect_thread = TW'(t);
    redirect_pc     = pc;
    run_cycle();
    redirect_valid  = 1'b0;
  endtask

  // Called at a negedge. Reset takes effect immediately, discarding any fetch.
  task automatic do_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    #1;
    check_eq("rst_InstRead", 32'(InstRead), 32'd0);
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_addr", InstByteAddress, 32'd0);
    check_eq("rst_word", inst_word, 32'd0);
    check_eq("rst_pc", inst_pc, 32'd0);
    check_eq("rst_thread", 32'(inst_thread), 32'd0);
    reset_n = 1'b1;
    check_outputs();
  endtask

  initial begin
    int seq;
    @(negedge clk);

    // Single thread: the first instruction comes from ROM bytes 0..3.
    thread_enable = 4'b0001;
    inst_ready    = 1'b1;
    do_reset();
    for (int cyc = 1; cyc <= 6; cyc++) begin
      run_cycle();
      if (cyc <= 4) check_eq("dir_addr", InstByteAddress, 32'(cyc - 1));
    end
    check_eq("dir_valid", 32'(inst_valid), 32'd1);
    check_eq("dir_word", inst_word, 32'h00A00513);
    run(20);

    // All threads enabled with ready tied high: strict rotation.
    thread_enable = 4'b1111;
    do_reset();
    seq = 0;
    repeat (60) begin
      run_cycle();
      if (m_busy && m_k >= 6) begin
        check_eq("rr_thread", 32'(inst_thread), 32'(seq % NT));
        check_eq("rr_pc", inst_pc, 32'(4 * (seq / NT)));
        seq++;
      end
    end

    // Backpressure: hold the instruction for 10 cycles.
    thread_enable = 4'b0001;
    do_reset();
    inst_ready = 1'b0;
    run(16);
    inst_ready = 1'b1;
    run(16);

    // Redirect thread 1 during its fetch at c=2.
    thread_enable = 4'b0010;
    do_reset();
    run(3);
    pulse_redirect(1, 32'h100);
    run(20);

    // Redirect thread 2 in HOLD with ready high, then thread 3 while 2 hands off.
    thread_enable = 4'b0100;
    do_reset();
    run(6);
    pulse_redirect(2, 32'h200);
    run(6);
    pulse_redirect(3, 32'h300);
    thread_enable = 4'b1100;
    run(30);

    // Address wrap; idle with no thread enabled.
    thread_enable = 4'b0000;
    do_reset();
    pulse_redirect(0, 32'hFFFF_FFFE);
    run(5);
    thread_enable = 4'b0001;
    run(16);

    // Randomized traffic with occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 15) == 0) thread_enable = NT'($urandom);
      inst_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 19) == 0);
      redirect_thread = TW'($urandom);
      redirect_pc     = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                                    : ($urandom & 32'h0000_0FFF);
      if ($urandom_range(0, 499) == 0) do_reset();
      else run_cycle();
    end
    redirect_valid = 1'b0;
    run(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
